// File: rtl/mips_cpu_pkg.sv
// ============================================================================
// Package : mips_cpu_pkg
// Shared MIPS CPU definitions: address defaults, fetch FSM states, byte swap.
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_cpu_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDRESS_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DELAY  = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } fetch_state_t;

    // Memory is little-endian; the core works on big-endian words.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_cpu_fetch_unit_if.sv
// ============================================================================
// Interface : mips_cpu_fetch_unit_if
// Instruction-memory bus between the fetch unit (master) and memory (slave).
// Rev 1.0
// ============================================================================
`default_nettype none

interface mips_cpu_fetch_unit_if;

    logic [31:0] instr_address;
    logic [31:0] instr_readdata;

    modport master (
        output instr_address,
        input  instr_readdata
    );

    modport slave (
        input  instr_address,
        output instr_readdata
    );

endinterface

`default_nettype wire

// File: rtl/mips_cpu_fetch_unit.sv
// ============================================================================
// Module : mips_cpu_fetch_unit
// PC owner with branch-delay-slot redirect, halt detection and fault capture.
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_cpu_fetch_unit
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] HALT_ADDRESS = HALT_ADDRESS_DEFAULT
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               clk_enable,
    input  wire logic               stall,
    input  wire logic               redirect_valid,
    input  wire logic [31:0]        redirect_target,
    mips_cpu_fetch_unit_if.master   imem,
    output      logic [31:0]        instr,
    output      logic [31:0]        pc_plus8,
    output      logic               active,
    output      logic               fault
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pending_q;
    logic         active_q;
    logic         fault_q;

    logic [31:0]  pc_d;
    logic         advance_w;
    logic         target_aligned_w;

    assign advance_w        = clk_enable && !stall;
    assign target_aligned_w = (redirect_target[1:0] == 2'b00);

    // In the delay slot the next fetch is the held target; otherwise sequential.
    assign pc_d = (state_q == ST_DELAY) ? pending_q : (pc_q + 32'd4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_VECTOR;
            pending_q <= 32'd0;
            active_q  <= 1'b1;
            fault_q   <= 1'b0;
        end else if (advance_w) begin
            case (state_q)
                ST_RUN: begin
                    if (redirect_valid && !target_aligned_w) begin
                        state_q  <= ST_FAULT;
                        active_q <= 1'b0;
                        fault_q  <= 1'b1;
                    end else begin
                        pc_q <= pc_d;
                        if (pc_d == HALT_ADDRESS) begin
                            state_q  <= ST_HALTED;
                            active_q <= 1'b0;
                        end else if (redirect_valid) begin
                            pending_q <= redirect_target;
                            state_q   <= ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    // A branch sitting in a delay slot is architecturally undefined.
                    if (redirect_valid) begin
                        state_q  <= ST_FAULT;
                        active_q <= 1'b0;
                        fault_q  <= 1'b1;
                    end else begin
                        pc_q <= pc_d;
                        if (pc_d == HALT_ADDRESS) begin
                            state_q  <= ST_HALTED;
                            active_q <= 1'b0;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign imem.instr_address = pc_q;
    assign instr              = byte_swap32(imem.instr_readdata);
    assign pc_plus8           = pc_q + 32'd8;
    assign active             = active_q;
    assign fault              = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_fetch_unit.sv
// ============================================================================
// Module : tb_mips_cpu_fetch_unit
// Directed and randomized checks of the fetch unit against a reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mips_cpu_fetch_unit;

    localparam logic [31:0] C_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] C_HALT_ADDRESS = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr;
    logic [31:0] pc_plus8;
    logic        active;
    logic        fault;

    mips_cpu_fetch_unit_if imem_if ();

    mips_cpu_fetch_unit #(
        .RESET_VECTOR (C_RESET_VECTOR),
        .HALT_ADDRESS (C_HALT_ADDRESS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_enable      (clk_enable),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem            (imem_if),
        .instr           (instr),
        .pc_plus8        (pc_plus8),
        .active          (active),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: architectural PC plus "a redirect is owed after one slot".
    logic [31:0] m_pc;
    logic [31:0] m_slot_target;
    bit          m_in_slot;
    bit          m_running;
    bit          m_fault;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] swap_ref(input logic [31:0] w);
        return ((w >> 24) & 32'h0000_00FF) | ((w >> 8) & 32'h0000_FF00) |
               ((w << 8)  & 32'h00FF_0000) | ((w << 24) & 32'hFF00_0000);
    endfunction

    task automatic check_all(input string tag);
        check_val({tag, "_addr"},  imem_if.instr_address, m_pc);
        check_val({tag, "_pc8"},   pc_plus8, m_pc + 32'd8);
        check_val({tag, "_act"},   {31'd0, active}, {31'd0, m_running});
        check_val({tag, "_fault"}, {31'd0, fault}, {31'd0, m_fault});
        check_val({tag, "_instr"}, instr, swap_ref(imem_if.instr_readdata));
    endtask

    task automatic model_reset();
        m_pc          = C_RESET_VECTOR;
        m_slot_target = 32'd0;
        m_in_slot     = 1'b0;
        m_running     = 1'b1;
        m_fault       = 1'b0;
    endtask

    task automatic model_edge();
        if (!m_running) return;
        if (m_in_slot) begin
            m_in_slot = 1'b0;
            if (redirect_valid) begin
                m_running = 1'b0;
                m_fault   = 1'b1;
            end else begin
                m_pc = m_slot_target;
                if (m_pc == C_HALT_ADDRESS) m_running = 1'b0;
            end
        end else if (redirect_valid && (redirect_target % 4 != 0)) begin
            m_running = 1'b0;
            m_fault   = 1'b1;
        end else begin
            m_pc = m_pc + 32'd4;
            if (m_pc == C_HALT_ADDRESS) m_running = 1'b0;
            else if (redirect_valid) begin
                m_in_slot     = 1'b1;
                m_slot_target = redirect_target;
            end
        end
    endtask

    task automatic drive(input bit ce, input bit st, input bit rv, input logic [31:0] tgt);
        clk_enable              = ce;
        stall                   = st;
        redirect_valid          = rv;
        redirect_target         = tgt;
        imem_if.instr_readdata  = $urandom;
    endtask

    // Inputs are driven after a falling edge; the model steps on the rising edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset && clk_enable && !stall) model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        model_reset();
        @(negedge clk);

        // Reset state
        do_reset("rst");
        check_val("rst_pc_lit", imem_if.instr_address, 32'hBFC0_0000);
        check_val("rst_act_lit", {31'd0, active}, 32'd1);

        // Sequential fetch
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'd0);
            tick("seq");
        end
        check_val("seq_pc_lit", imem_if.instr_address, 32'hBFC0_0010);
        check_val("seq_pc8_lit", pc_plus8, 32'hBFC0_0018);

        // Byte swap
        imem_if.instr_readdata = 32'h4B01_2524;
        #1;
        check_val("swap_lit", instr, 32'h2425_014B);

        // Jump to halt address with delay slot
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0000);
        tick("jr0");
        check_val("jr0_slot_lit", imem_if.instr_address, 32'hBFC0_0014);
        check_val("jr0_slot_act", {31'd0, active}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick("jr0b");
        check_val("halt_pc_lit", imem_if.instr_address, 32'h0000_0000);
        check_val("halt_act_lit", {31'd0, active}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, (i == 0), 32'hBFC0_0100);
            tick("halted");
        end

        // Stall during delay slot; redirect raised while stalled is ignored
        do_reset("rst5");
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick("t5a");
        tick("t5b");
        drive(1'b1, 1'b0, 1'b1, 32'hBFC0_0040);
        tick("t5br");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 32'hBFC0_0080);
            tick("t5stall");
        end
        check_val("stall_pc_lit", imem_if.instr_address, 32'hBFC0_000C);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick("t5go");
        check_val("stall_tgt_lit", imem_if.instr_address, 32'hBFC0_0040);

        // clk_enable low freezes everything
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'hBFC0_0003);
            tick("ce0");
        end

        // Misaligned target faults
        drive(1'b1, 1'b0, 1'b1, 32'hBFC0_0022);
        tick("mis");
        check_val("mis_fault_lit", {31'd0, fault}, 32'd1);
        check_val("mis_act_lit", {31'd0, active}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick("mis_hold");

        // Reset during delay slot discards pending target
        do_reset("rst6");
        drive(1'b1, 1'b0, 1'b1, 32'hBFC0_0080);
        tick("t6br");
        do_reset("rst6d");
        check_val("rst6_fault_lit", {31'd0, fault}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick("t6after");
        check_val("rst6_seq_lit", imem_if.instr_address, 32'hBFC0_0004);

        // Redirect inside a delay slot faults
        drive(1'b1, 1'b0, 1'b1, 32'hBFC0_0200);
        tick("dsa");
        drive(1'b1, 1'b0, 1'b1, 32'hBFC0_0300);
        tick("dsb");
        check_val("ds_fault_lit", {31'd0, fault}, 32'd1);

        // Wraparound 0xFFFFFFFC + 4 reaches halt address
        do_reset("rstw");
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        tick("wbr");
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) tick("wrap");
        check_val("wrap_act_lit", {31'd0, active}, 32'd0);
        check_val("wrap_pc_lit", imem_if.instr_address, 32'h0000_0000);

        // Randomized traffic
        do_reset("rstr");
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            int          sel;
            if ((!m_running && ($urandom % 4 == 0)) || ($urandom % 50 == 0)) begin
                do_reset("rrst");
            end
            sel = $urandom % 16;
            if (sel == 0)      tgt = 32'h0000_0000;
            else if (sel == 1) tgt = C_RESET_VECTOR + (($urandom % 64) * 4) + 32'($urandom_range(1, 3));
            else               tgt = C_RESET_VECTOR + (($urandom % 256) * 4);
            drive(($urandom % 8) != 0, ($urandom % 5) == 0, ($urandom % 4) == 0, tgt);
            tick("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
